// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with an
// optional write-to-read bypass, a per-register busy scoreboard and a
// hardware clear sequence that zeroes x1..x(DEPTH-1) after reset.
module regfile_mp #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NRD*$clog2(DEPTH)-1:0] i_rnum,
    output logic [NRD*WIDTH-1:0]         o_rd,
    output logic [NRD-1:0]               o_busy,
    input  logic                         i_wen,
    input  logic [$clog2(DEPTH)-1:0]     i_wnum,
    input  logic [WIDTH-1:0]             i_wd,
    input  logic                         i_set_busy,
    input  logic [$clog2(DEPTH)-1:0]     i_busy_num,
    output logic                         o_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             run;
    logic             wr_ok;
    logic             set_ok;

    assign run     = (state == ST_RUN);
    assign wr_ok   = run && i_wen && (i_wnum != '0);
    assign set_ok  = run && i_set_busy && (i_busy_num != '0);
    assign o_ready = run;

    // Control: clear-sequence counter, state and busy scoreboard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= AW'(1);
            busy    <= '0;
        end else begin
            busy <= busy_nxt;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + AW'(1);
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // Next busy vector: a writeback retires its producer, a new issue sets it (set wins)
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[i_wnum] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[i_busy_num] = 1'b1;
        end
    end

    // Array storage: zero-fill during CLEAR, writeback during RUN (no reset on data)
    always_ff @(posedge i_clk) begin
        if (!run) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[i_wnum] <= i_wd;
        end
    end

    // Read ports: x0 and CLEAR read as zero; a same-cycle write is forwarded when BYPASS
    always_comb begin
        o_rd   = '0;
        o_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            ra = i_rnum[k*AW +: AW];
            if (run && (ra != '0)) begin
                if (BYPASS && i_wen && (i_wnum == ra)) begin
                    o_rd[k*WIDTH +: WIDTH] = i_wd;
                end else begin
                    o_rd[k*WIDTH +: WIDTH] = mem[ra];
                    o_busy[k]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Three instances run side by
// side: A (32x32, 2 ports, bypass), B (same, no bypass, same inputs as A) and
// C (64x16, 3 ports, bypass). Stimulus pushes expectations, a monitor checks.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    logic [9:0]   rn_ab;
    logic         wen_ab;
    logic [4:0]   wnum_ab;
    logic [31:0]  wd_ab;
    logic         set_ab;
    logic [4:0]   bnum_ab;
    logic [63:0]  rd_a, rd_b;
    logic [1:0]   busy_a, busy_b;
    logic         rdy_a, rdy_b;

    logic [11:0]  rn_c;
    logic         wen_c;
    logic [3:0]   wnum_c;
    logic [63:0]  wd_c;
    logic         set_c;
    logic [3:0]   bnum_c;
    logic [191:0] rd_c;
    logic [2:0]   busy_c;
    logic         rdy_c;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rnum(rn_ab), .o_rd(rd_a), .o_busy(busy_a),
        .i_wen(wen_ab), .i_wnum(wnum_ab), .i_wd(wd_ab), .i_set_busy(set_ab),
        .i_busy_num(bnum_ab), .o_ready(rdy_a));

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rnum(rn_ab), .o_rd(rd_b), .o_busy(busy_b),
        .i_wen(wen_ab), .i_wnum(wnum_ab), .i_wd(wd_ab), .i_set_busy(set_ab),
        .i_busy_num(bnum_ab), .o_ready(rdy_b));

    regfile_mp #(.WIDTH(64), .DEPTH(16), .NRD(3), .BYPASS(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rnum(rn_c), .o_rd(rd_c), .o_busy(busy_c),
        .i_wen(wen_c), .i_wnum(wnum_c), .i_wd(wd_c), .i_set_busy(set_c),
        .i_busy_num(bnum_c), .o_ready(rdy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           cyc;
        logic [63:0]  rd_a, rd_b;
        logic [191:0] rd_c;
        logic [1:0]   bz_a, bz_b;
        logic [2:0]   bz_c;
        logic         ry_a, ry_b, ry_c;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: architectural contents, busy flags, edges since reset release
    logic [31:0] m_ab [32];
    bit          b_ab [32];
    logic [63:0] m_c  [16];
    bit          b_c  [16];
    int          edges = 0;

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp, input int c);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    endtask

    // Advance one rising edge and apply its effect to the model
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (edges >= 31) begin
                if (wen_ab && wnum_ab != 0) begin m_ab[wnum_ab] = wd_ab; b_ab[wnum_ab] = 0; end
                if (set_ab && bnum_ab != 0) b_ab[bnum_ab] = 1;
            end
            if (edges >= 15) begin
                if (wen_c && wnum_c != 0) begin m_c[wnum_c] = wd_c; b_c[wnum_c] = 0; end
                if (set_c && bnum_c != 0) b_c[bnum_c] = 1;
            end
            edges++;
            if (edges == 31) foreach (m_ab[i]) m_ab[i] = '0;
            if (edges == 15) foreach (m_c[i]) m_c[i] = '0;
        end
        #1;
    endtask

    task automatic assert_rst();
        rst_n = 1'b0;
        edges = 0;
        foreach (b_ab[i]) b_ab[i] = 0;
        foreach (b_c[i])  b_c[i]  = 0;
    endtask

    // Expected outputs for the inputs currently applied
    task automatic push_exp();
        exp_t e;
        e.cyc  = cyc;
        e.ry_a = (edges >= 31);
        e.ry_b = (edges >= 31);
        e.ry_c = (edges >= 15);
        e.rd_a = '0; e.rd_b = '0; e.rd_c = '0;
        e.bz_a = '0; e.bz_b = '0; e.bz_c = '0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] a;
            a = rn_ab[k*5 +: 5];
            if (e.ry_a && a != 0) begin
                if (wen_ab && wnum_ab == a) e.rd_a[k*32 +: 32] = wd_ab;
                else begin e.rd_a[k*32 +: 32] = m_ab[a]; e.bz_a[k] = b_ab[a]; end
                e.rd_b[k*32 +: 32] = m_ab[a];
                e.bz_b[k]          = b_ab[a];
            end
        end
        for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            a = rn_c[k*4 +: 4];
            if (e.ry_c && a != 0) begin
                if (wen_c && wnum_c == a) e.rd_c[k*64 +: 64] = wd_c;
                else begin e.rd_c[k*64 +: 64] = m_c[a]; e.bz_c[k] = b_c[a]; end
            end
        end
        q.push_back(e);
    endtask

    // Monitor: compare DUT outputs with every expectation due this cycle
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("rd_a",    192'(rd_a),   192'(e.rd_a), e.cyc);
                chk("rd_b",    192'(rd_b),   192'(e.rd_b), e.cyc);
                chk("rd_c",    rd_c,         e.rd_c,       e.cyc);
                chk("busy_a",  192'(busy_a), 192'(e.bz_a), e.cyc);
                chk("busy_b",  192'(busy_b), 192'(e.bz_b), e.cyc);
                chk("busy_c",  192'(busy_c), 192'(e.bz_c), e.cyc);
                chk("ready_a", 192'(rdy_a),  192'(e.ry_a), e.cyc);
                chk("ready_b", 192'(rdy_b),  192'(e.ry_b), e.cyc);
                chk("ready_c", 192'(rdy_c),  192'(e.ry_c), e.cyc);
            end
        end
    end

    task automatic idle();
        wen_ab = 0; set_ab = 0; wnum_ab = '0; bnum_ab = '0; wd_ab = '0;
        wen_c  = 0; set_c  = 0; wnum_c  = '0; bnum_c  = '0; wd_c  = '0;
    endtask

    task automatic rand_reads();
        rn_ab = 10'($urandom);
        rn_c  = 12'($urandom);
    endtask

    task automatic rand_all();
        rand_reads();
        if ($urandom_range(0, 1) == 1) begin
            rn_ab = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rn_c  = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
        end
        wen_ab  = 1'($urandom_range(0, 1));
        wnum_ab = 5'($urandom_range(0, 7));
        wd_ab   = $urandom;
        set_ab  = ($urandom_range(0, 2) == 0);
        bnum_ab = 5'($urandom_range(0, 7));
        wen_c   = 1'($urandom_range(0, 1));
        wnum_c  = 4'($urandom_range(0, 5));
        wd_c    = {$urandom, $urandom};
        set_c   = ($urandom_range(0, 2) == 0);
        bnum_c  = 4'($urandom_range(0, 5));
    endtask

    // Write/set-busy attempts on x3 that must be ignored while clearing
    task automatic clear_ops();
        rand_reads();
        idle();
        if (edges < 31) begin wen_ab = 1; wnum_ab = 5'd3; wd_ab = 32'hFF; set_ab = 1; bnum_ab = 5'd3; end
        if (edges < 15) begin wen_c = 1; wnum_c = 4'd3; wd_c = 64'hFF; set_c = 1; bnum_c = 4'd3; end
    endtask

    initial begin
        rst_n = 1'b0;
        rn_ab = '0; rn_c = '0;
        idle();
        foreach (m_ab[i]) m_ab[i] = '0;
        foreach (m_c[i])  m_c[i]  = '0;

        // Reset state, then clear sequence interrupted at edge 10
        tick(); assert_rst(); push_exp();
        tick(); rst_n = 1'b1; push_exp();
        repeat (9) begin tick(); clear_ops(); push_exp(); end
        tick(); assert_rst(); clear_ops(); push_exp();
        tick(); rst_n = 1'b1; clear_ops(); push_exp();
        repeat (40) begin tick(); clear_ops(); push_exp(); end

        // x3 must read zero and not busy after the ignored ops
        tick(); idle(); rn_ab = {5'd3, 5'd3}; rn_c = {4'd3, 4'd3, 4'd3}; push_exp();

        // Preload garbage and busy flags, then reset and check the clear
        for (int r = 1; r < 32; r++) begin
            tick(); rand_reads();
            wen_ab = 1; wnum_ab = 5'(r); wd_ab = $urandom; set_ab = 1; bnum_ab = 5'($urandom);
            wen_c = 1; wnum_c = 4'(r % 16); wd_c = {$urandom, $urandom}; set_c = 1; bnum_c = 4'($urandom);
            push_exp();
        end
        tick(); assert_rst(); idle(); push_exp();
        tick(); rst_n = 1'b1; push_exp();
        repeat (31) begin tick(); rand_reads(); push_exp(); end
        for (int r = 0; r < 16; r++) begin
            tick(); rn_ab = {5'(2*r + 1), 5'(2*r)}; rn_c = {4'(r), 4'(r), 4'(r)}; push_exp();
        end

        // Basic write/read and x0 hardwiring
        tick(); wen_ab = 1; wnum_ab = 5'd5; wd_ab = 32'hDEADBEEF; push_exp();
        tick(); idle(); rn_ab = {5'd5, 5'd5}; push_exp();
        tick(); wen_ab = 1; wnum_ab = 5'd0; wd_ab = 32'h1234; rn_ab = '0; push_exp();
        tick(); idle(); rn_ab = '0; push_exp();

        // Bypass versus pre-write value
        tick(); wen_ab = 1; wnum_ab = 5'd7; wd_ab = 32'h1; push_exp();
        tick(); wd_ab = 32'hA5A5A5A5; rn_ab = {5'd7, 5'd0}; push_exp();
        tick(); idle(); rn_ab = {5'd7, 5'd7}; push_exp();

        // Busy scoreboard
        tick(); set_ab = 1; bnum_ab = 5'd9; rn_ab = {5'd9, 5'd9}; push_exp();
        tick(); idle(); push_exp();
        tick(); wen_ab = 1; wnum_ab = 5'd9; wd_ab = 32'h42; push_exp();
        tick(); idle(); push_exp();
        tick(); wen_ab = 1; wnum_ab = 5'd9; wd_ab = 32'h43; set_ab = 1; bnum_ab = 5'd9; push_exp();
        tick(); idle(); push_exp();

        // Wide instance: all three ports on x15
        tick(); wen_c = 1; wnum_c = 4'd15; wd_c = 64'hFFFF_0000_FFFF_0000; rn_c = '0; push_exp();
        tick(); idle(); rn_c = {4'd15, 4'd15, 4'd15}; push_exp();

        // Random traffic, a mid-run reset, and random traffic across the clear
        repeat (400) begin tick(); rand_all(); push_exp(); end
        tick(); assert_rst(); rand_all(); push_exp();
        tick(); rst_n = 1'b1; rand_all(); push_exp();
        repeat (300) begin tick(); rand_all(); push_exp(); end

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d want=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised, multi-read-port integer register file for the SOIN-RV core, the next generation of the x0..x31 register file. It adds configurable width, depth and read-port count, an optional write-to-read bypass, and a hardware clear sequence after reset. It also adds a per-register busy scoreboard that the decode stage uses for hazard detection. It sits between decode (read and busy-set) and writeback (write).

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2. AW = $clog2(DEPTH).
- NRD, 2, number of read ports, ≥ 1.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the pre-write value.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised upstream.
- i_rnum  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rd  out  NRD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]. Combinational.
- o_busy  out  NRD  busy flag of the register addressed by each read port. Combinational.
- i_wen  in  1  write enable.
- i_wnum  in  AW  write address.
- i_wd  in  WIDTH  write data.
- i_set_busy  in  1  mark register i_busy_num as having a pending producer.
- i_busy_num  in  AW  register to mark busy.
- o_ready  out  1  high once the clear sequence is done; registered.

## Operation
- Register 0 is hardwired:
  - Reads of address 0 always return 0 with o_busy 0.
  - Writes to address 0 are discarded.
  - Set-busy on address 0 is ignored.
- FSM states: CLEAR, RUN.
- Reset assertion (asynchronous, at any time, including mid-sequence or mid-run):
  - State goes to CLEAR; clear counter = 1.
  - o_ready = 0; all busy bits = 0.
  - Array contents are not reset directly; they are zeroed by the clear sequence.
- CLEAR state:
  - Each rising edge writes 0 to x[cnt], then cnt increments.
  - When cnt == DEPTH-1 is written, the next state is RUN and o_ready goes to 1 on that same edge.
  - i_wen and i_set_busy are ignored.
  - All o_rd and o_busy outputs are forced to 0.
- RUN state:
  - Write: if i_wen and i_wnum ≠ 0, then x[i_wnum] ← i_wd on the rising edge.
  - Busy clear: if i_wen and i_wnum ≠ 0, then busy[i_wnum] ← 0.
  - Busy set: if i_set_busy and i_busy_num ≠ 0, then busy[i_busy_num] ← 1.
  - If set and clear hit the same register on the same edge, set wins (a new producer was issued).
- Read port k, RUN state, address a = i_rnum[k]:
  - a == 0: o_rd = 0, o_busy = 0.
  - BYPASS = 1, i_wen = 1 and i_wnum == a: o_rd = i_wd and o_busy = 0 (the result is available now).
  - Otherwise: o_rd = x[a], o_busy = busy[a].
- All read ports are independent. Any number of ports may address the same register.

## Timing
- Read latency is 0 cycles (combinational from i_rnum, and from i_wen/i_wnum/i_wd when BYPASS = 1).
- Write latency is 1 edge. With BYPASS = 0, the new value is visible on the cycle after the write.
- Busy set is visible on the cycle after the i_set_busy edge. Busy clear is visible the same cycle via the bypass mask (BYPASS = 1) or the next cycle (BYPASS = 0).
- Clear sequence: DEPTH-1 rising edges after reset release. o_ready rises on edge DEPTH-1; for DEPTH = 32 that is edge 31.
- Reset values of outputs:
  - o_ready = 0.
  - o_rd = all 0.
  - o_busy = all 0.
- Reset asserted mid-CLEAR restarts the sequence at cnt = 1 after release.

## Test plan
- Clear sequence: preload the array with garbage, pulse i_rst_n low, release. Required: o_ready = 0 for edges 1..30 and rises on edge 31 (DEPTH = 32); all 31 registers then read 0. Reassert reset at edge 10 → o_ready stays 0 and the full 31-edge count restarts.
- Basic write/read: write x5 = 0xDEADBEEF, then read x5 on ports 0 and 1 the next cycle → both return 0xDEADBEEF. Write x0 = 0x1234 → reads of x0 return 0.
- Bypass: in the same cycle as a write of x7 = 0xA5A5A5A5 (previously 0x1), read x7 on port 1. BYPASS = 1 → 0xA5A5A5A5 that cycle. BYPASS = 0 → 0x1 that cycle, 0xA5A5A5A5 the next.
- Scoreboard: set busy x9, then read x9 → o_busy = 1. Write x9 = 0x42 → with BYPASS = 1, o_busy = 0 in the write cycle, and busy stays 0 afterwards. Set busy and write x9 on the same edge → o_busy = 1 the next cycle.
- Ignored ops during CLEAR: assert i_wen (x3 = 0xFF) and i_set_busy (x3) during CLEAR. After o_ready, x3 reads 0 and o_busy = 0.
- Parametrisation: WIDTH = 64, DEPTH = 16, NRD = 3. Write x15 = 0xFFFF_0000_FFFF_0000 and read x15 on all 3 ports → every port matches. The clear sequence takes 15 edges.
